branch_target_buffer: RTL and testbench

Direct-mapped branch target buffer with 2-bit saturating confidence counters, sitting beside the fetch stage of the 5-stage RV64 pipeline. Each cycle it looks up the fetch PC combinationally and reports a predicted target when a confident entry exists. It is trained by the execute stage with the resolved direction and target of the instruction currently in EX.

---
 rtl/branch_target_buffer.sv | 91 +++++++++
 tb/tb_branch_target_buffer.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/branch_target_buffer.sv
// Direct-mapped branch target buffer with 2-bit saturating confidence counters.
// Lookup is combinational on the fetch PC; training from EX commits at the rising edge.
module branch_target_buffer #(
    parameter int unsigned ENTRIES    = 64,
    parameter int unsigned INDEX_BITS = $clog2(ENTRIES),
    parameter int unsigned TAG_BITS   = 62 - INDEX_BITS
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [63:0] pc_if,
    input  logic [63:0] pc_ex,
    input  logic        branch_taken_ex,
    input  logic [63:0] target_addr_ex,
    output logic [63:0] predicted_target,
    output logic        hit
);

    logic                  valid_q  [ENTRIES];
    logic                  valid_d  [ENTRIES];
    logic [1:0]            ctr_q    [ENTRIES];
    logic [1:0]            ctr_d    [ENTRIES];
    logic [TAG_BITS-1:0]   tag_q    [ENTRIES];
    logic [TAG_BITS-1:0]   tag_d    [ENTRIES];
    logic [63:0]           target_q [ENTRIES];
    logic [63:0]           target_d [ENTRIES];

    logic [INDEX_BITS-1:0] idx_if;
    logic [INDEX_BITS-1:0] idx_ex;
    logic [TAG_BITS-1:0]   tag_if;
    logic [TAG_BITS-1:0]   tag_ex;
    logic                  match_if;
    logic                  match_ex;

    // PC bits [1:0] never reach the table.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{pc_if[1:0], pc_ex[1:0]};

    assign idx_if = pc_if[INDEX_BITS+1:2];
    assign tag_if = pc_if[63:INDEX_BITS+2];
    assign idx_ex = pc_ex[INDEX_BITS+1:2];
    assign tag_ex = pc_ex[63:INDEX_BITS+2];

    always_comb begin
        match_if         = valid_q[idx_if] && (tag_q[idx_if] == tag_if);
        hit              = match_if && ctr_q[idx_if][1];
        predicted_target = hit ? target_q[idx_if] : 64'h0;
    end

    always_comb begin
        valid_d  = valid_q;
        ctr_d    = ctr_q;
        tag_d    = tag_q;
        target_d = target_q;
        match_ex = valid_q[idx_ex] && (tag_q[idx_ex] == tag_ex);
        if (branch_taken_ex) begin
            if (match_ex) begin
                if (ctr_q[idx_ex] != 2'b11) begin
                    ctr_d[idx_ex] = ctr_q[idx_ex] + 2'd1;
                end
                target_d[idx_ex] = target_addr_ex;
            end else begin
                // Allocate (or evict an alias) as weakly taken.
                valid_d[idx_ex]  = 1'b1;
                tag_d[idx_ex]    = tag_ex;
                target_d[idx_ex] = target_addr_ex;
                ctr_d[idx_ex]    = 2'b10;
            end
        end else if (match_ex && (ctr_q[idx_ex] != 2'b00)) begin
            ctr_d[idx_ex] = ctr_q[idx_ex] - 2'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i] <= 1'b0;
                ctr_q[i]   <= 2'b00;
            end
        end else begin
            valid_q <= valid_d;
            ctr_q   <= ctr_d;
        end
    end

    // Tags and targets are qualified by valid, so they need no reset.
    always_ff @(posedge clk) begin
        tag_q    <= tag_d;
        target_q <= target_d;
    end

endmodule

// File: tb/tb_branch_target_buffer.sv
// Self-checking bench for branch_target_buffer: directed scenarios plus randomized
// training/lookup traffic compared against an arithmetic reference model.
module tb_branch_target_buffer;

    localparam int unsigned ENTRIES = 64;

    logic        clk;
    logic        reset;
    logic [63:0] pc_if;
    logic [63:0] pc_ex;
    logic        branch_taken_ex;
    logic [63:0] target_addr_ex;
    logic [63:0] predicted_target;
    logic        hit;

    int checks;
    int errors;

    // Reference model: one record per index, keyed by plain division arithmetic.
    bit              m_valid [ENTRIES];
    longint unsigned m_tag   [ENTRIES];
    longint unsigned m_tgt   [ENTRIES];
    int              m_ctr   [ENTRIES];

    branch_target_buffer #(
        .ENTRIES(ENTRIES)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .pc_if            (pc_if),
        .pc_ex            (pc_ex),
        .branch_taken_ex  (branch_taken_ex),
        .target_addr_ex   (target_addr_ex),
        .predicted_target (predicted_target),
        .hit              (hit)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int unsigned m_idx(input longint unsigned pc);
        return int'((pc / 4) % ENTRIES);
    endfunction

    function automatic longint unsigned m_tagof(input longint unsigned pc);
        return pc / (4 * ENTRIES);
    endfunction

    function automatic bit m_match(input longint unsigned pc);
        int unsigned i;
        i = m_idx(pc);
        return m_valid[i] && (m_tag[i] == m_tagof(pc));
    endfunction

    task automatic m_lookup(input longint unsigned pc, output logic eh,
                            output logic [63:0] et);
        int unsigned i;
        i  = m_idx(pc);
        eh = m_match(pc) && (m_ctr[i] >= 2);
        et = eh ? m_tgt[i] : 64'h0;
    endtask

    task automatic m_train(input longint unsigned pc, input bit tk, input longint unsigned tgt);
        int unsigned i;
        i = m_idx(pc);
        if (tk) begin
            if (m_match(pc)) begin
                m_ctr[i] = (m_ctr[i] + 1 > 3) ? 3 : m_ctr[i] + 1;
                m_tgt[i] = tgt;
            end else begin
                m_valid[i] = 1'b1;
                m_tag[i]   = m_tagof(pc);
                m_tgt[i]   = tgt;
                m_ctr[i]   = 2;
            end
        end else if (m_match(pc)) begin
            m_ctr[i] = (m_ctr[i] - 1 < 0) ? 0 : m_ctr[i] - 1;
        end
    endtask

    task automatic m_clear();
        for (int i = 0; i < ENTRIES; i++) begin
            m_valid[i] = 1'b0;
            m_ctr[i]   = 0;
        end
    endtask

    // One clock: drive, check lookup against pre-edge model, then apply training.
    task automatic cycle(input logic [63:0] pif, input logic [63:0] pex, input logic tk,
                         input logic [63:0] tgt, input string tag);
        logic        eh;
        logic [63:0] et;
        pc_if           = pif;
        pc_ex           = pex;
        branch_taken_ex = tk;
        target_addr_ex  = tgt;
        @(negedge clk);
        m_lookup(pif, eh, et);
        check_eq({tag, "_hit"}, {63'h0, hit}, {63'h0, eh});
        check_eq({tag, "_tgt"}, predicted_target, et);
        @(posedge clk);
        m_train(pex, tk, tgt);
        #1;
    endtask

    // Lookup-only cycle that also pins the result to an explicit expectation.
    task automatic probe(input logic [63:0] pif, input logic eh, input logic [63:0] et,
                         input string tag);
        pc_if           = pif;
        pc_ex           = 64'hdead_0000;
        branch_taken_ex = 1'b0;
        #1;
        check_eq({tag, "_hit"}, {63'h0, hit}, {63'h0, eh});
        check_eq({tag, "_tgt"}, predicted_target, et);
        cycle(pif, 64'hdead_0000, 1'b0, 64'h0, tag);
    endtask

    function automatic logic [63:0] rand_pc();
        longint unsigned t;
        longint unsigned i;
        case ($urandom_range(0, 3))
            0:       t = 0;
            1:       t = 1;
            2:       t = 2;
            default: t = {$urandom, $urandom} >> 8;
        endcase
        i = $urandom_range(0, 3);
        return t * (4 * ENTRIES) + i * 4 + $urandom_range(0, 3);
    endfunction

    initial begin
        logic [63:0] p;
        checks          = 0;
        errors          = 0;
        pc_if           = 64'h0;
        pc_ex           = 64'h0;
        branch_taken_ex = 1'b0;
        target_addr_ex  = 64'h0;
        reset           = 1'b0;
        m_clear();

        #12;
        check_eq("rst_hit", {63'h0, hit}, 64'h0);
        check_eq("rst_tgt", predicted_target, 64'h0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;

        // Allocation is invisible in the training cycle, visible the next.
        cycle(64'h1000, 64'h1000, 1'b1, 64'h2000, "alloc_same");
        probe(64'h1000, 1'b1, 64'h2000, "alloc_next");

        // Hysteresis: ctr 10 -> 11 (two more takens) -> 10 -> 01 -> 10.
        cycle(64'h1000, 64'h1000, 1'b1, 64'h2000, "hyst_t2");
        cycle(64'h1000, 64'h1000, 1'b1, 64'h2000, "hyst_t3");
        cycle(64'h1000, 64'h1000, 1'b0, 64'h0, "hyst_nt1");
        probe(64'h1000, 1'b1, 64'h2000, "hyst_still");
        cycle(64'h1000, 64'h1000, 1'b0, 64'h0, "hyst_nt2");
        probe(64'h1000, 1'b0, 64'h0, "hyst_weak");
        cycle(64'h1000, 64'h1000, 1'b1, 64'h3000, "retarget");
        probe(64'h1000, 1'b1, 64'h3000, "retarget_chk");

        // 0x1100 shares index 0 with 0x1000 and evicts it.
        cycle(64'h1100, 64'h1100, 1'b1, 64'h4000, "alias_alloc");
        probe(64'h1000, 1'b0, 64'h0, "alias_old");
        probe(64'h1100, 1'b1, 64'h4000, "alias_new");
        cycle(64'h1100, 64'h1000, 1'b0, 64'h0, "alias_nt");
        probe(64'h1100, 1'b1, 64'h4000, "alias_kept");

        cycle(64'h2004, 64'h2004, 1'b1, 64'h5000, "second_alloc");
        for (int n = 0; n < 100; n++) begin
            do p = {$urandom, $urandom}; while (m_match(p));
            cycle({$urandom, $urandom}, p, 1'b0, {$urandom, $urandom}, "bubble");
        end
        probe(64'h1100, 1'b1, 64'h4000, "bubble_keep0");
        probe(64'h2004, 1'b1, 64'h5000, "bubble_keep1");

        // Asynchronous reset mid-cycle clears hit immediately.
        pc_if = 64'h1100;
        @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        check_eq("async_rst_hit", {63'h0, hit}, 64'h0);
        check_eq("async_rst_tgt", predicted_target, 64'h0);
        m_clear();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        probe(64'h1000, 1'b0, 64'h0, "post_rst_a");
        probe(64'h1100, 1'b0, 64'h0, "post_rst_b");

        for (int n = 0; n < 3000; n++) begin
            cycle(rand_pc(), rand_pc(), 1'($urandom_range(0, 1)), {$urandom, $urandom}, "rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
